// File: rtl/arm_multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle ARM controller: FSM states, ALU/mux
// select codes and condition field values.
package arm_multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    // Data-processing command field, Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_RD2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_INC = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] SH_ROR = 2'b11;

endpackage

// File: rtl/arm_multicycle_controller_cond_unit.sv
// NZCV flag register and condition evaluation; flag writes only land when
// the instruction's condition passes.
module cond_unit
    import arm_multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cond,
    input  logic [3:0] aluflags,
    input  logic       flagw,
    output logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        condex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: condex = z;
            COND_NE: condex = !z;
            COND_CS: condex = c;
            COND_CC: condex = !c;
            COND_MI: condex = n;
            COND_PL: condex = !n;
            COND_VS: condex = v;
            COND_VC: condex = !v;
            COND_HI: condex = c && !z;
            COND_LS: condex = !c || z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = !z && (n == v);
            COND_LE: condex = z || (n != v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            flags <= '0;
        else if (flagw && condex)
            flags <= aluflags;
    end

endmodule

// File: rtl/arm_multicycle_controller.sv
// Multi-cycle ARM control unit: Moore main FSM with combinational ALU,
// shifter and immediate decode driving a shared datapath.
module arm_multicycle_controller
    import arm_multicycle_controller_pkg::*;
#(
    parameter int unsigned FETCH_INC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  RegSrc,
    output logic [3:0]  ALUControl,
    output logic [1:0]  Shifter_control,
    output logic [4:0]  shamt,
    output logic [3:0]  Flags,
    output logic [3:0]  state
);

    state_t cur, nxt;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rd_pc, is_store;
    logic       irw, pcw_raw, rw_raw, mw_raw, flagw;
    logic       condex, en;

    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign cmd      = funct[4:1];
    assign rd_pc    = (Instr[15:12] == 4'hF);
    assign is_store = (op == 2'b01) && !funct[0];

    // FETCH_INC feeds the datapath constant mux, not this unit
    logic unused_ok;
    assign unused_ok = ^{Instr[19:16], Instr[4:0], 32'(FETCH_INC)};

    always_ff @(posedge clk) begin
        if (!reset_n)
            cur <= FETCH;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt             = FETCH;
        irw             = 1'b0;
        pcw_raw         = 1'b0;
        rw_raw          = 1'b0;
        mw_raw          = 1'b0;
        flagw           = 1'b0;
        AdrSrc          = 1'b0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = SRCB_RD2;
        ResultSrc       = RES_ALUOUT;
        ImmSrc          = IMM_8;
        RegSrc          = '0;
        ALUControl      = ALU_ADD;
        Shifter_control = '0;
        shamt           = '0;
        case (cur)
            FETCH: begin
                irw       = 1'b1;
                pcw_raw   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_INC;
                ResultSrc = RES_ALU;
                nxt       = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_INC;
                RegSrc[0] = (op == 2'b10);
                RegSrc[1] = is_store;
                case (op)
                    2'b01: nxt = MEMADR;
                    2'b10: nxt = BRANCH;
                    2'b00: begin
                        if (funct == 6'b010010 && rd_pc) nxt = BRANCH;
                        else if (funct[5])               nxt = EXECUTEI;
                        else                             nxt = EXECUTER;
                    end
                    default: nxt = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_12;
                ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
                RegSrc[1]  = is_store;
                nxt        = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                nxt    = MEMWB;
            end
            MEMWB: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_DATA;
                rw_raw    = 1'b1;
                pcw_raw   = rd_pc;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mw_raw    = 1'b1;
                RegSrc[1] = 1'b1;
            end
            EXECUTER, EXECUTEI: begin
                if (cur == EXECUTEI) begin
                    ALUSrcB         = SRCB_IMM;
                    ImmSrc          = IMM_8;
                    Shifter_control = SH_ROR;
                    shamt           = {Instr[11:8], 1'b0};
                end else begin
                    Shifter_control = Instr[6:5];
                    shamt           = Instr[11:7];
                end
                case (cmd)
                    CMD_AND: begin ALUControl = ALU_AND; nxt = ALUWB; end
                    CMD_ORR: begin ALUControl = ALU_ORR; nxt = ALUWB; end
                    CMD_ADD: begin ALUControl = ALU_ADD; nxt = ALUWB; end
                    CMD_SUB: begin ALUControl = ALU_SUB; nxt = ALUWB; end
                    CMD_MOV: begin ALUControl = ALU_MOV; nxt = ALUWB; end
                    CMD_CMP: begin ALUControl = ALU_SUB; flagw = 1'b1; end
                    default: nxt = FETCH;
                endcase
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                rw_raw    = 1'b1;
                pcw_raw   = rd_pc;
            end
            BRANCH: begin
                ResultSrc = RES_ALU;
                pcw_raw   = 1'b1;
                if (op == 2'b10) begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_IMM;
                    ImmSrc     = IMM_24;
                    RegSrc[0]  = 1'b1;
                    rw_raw     = funct[4];
                    RegSrc[2]  = funct[4];
                end else begin
                    ALUControl = ALU_MOV;
                end
            end
            default: nxt = FETCH;
        endcase
    end

    // FETCH is never conditional; every later side effect waits on CondEx
    assign en       = (cur == FETCH) || condex;
    assign IRWrite  = irw && reset_n;
    assign PCWrite  = pcw_raw && en && reset_n;
    assign RegWrite = rw_raw && en && reset_n;
    assign MemWrite = mw_raw && en && reset_n;
    assign state    = cur;

    cond_unit u_cond (
        .clk      (clk),
        .reset_n  (reset_n),
        .cond     (Instr[31:28]),
        .aluflags (ALUFlags),
        .flagw    (flagw),
        .flags    (Flags),
        .condex   (condex)
    );

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Bench for arm_multicycle_controller: directed instructions plus random
// instruction words checked against an instruction-level reference model.
module tb_arm_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        IRWrite, PCWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, Shifter_control;
    logic [2:0]  RegSrc;
    logic [3:0]  ALUControl, Flags, state;
    logic [4:0]  shamt;

    int errors = 0;
    int checks = 0;

    logic [3:0] mflags;

    typedef struct {
        int st;
        bit irw, pcw, rw, mw;
    } step_t;
    step_t exp_q[$];

    logic [3:0] cap_aluc   [16];
    logic       cap_adrsrc [16];
    logic [1:0] cap_res    [16];
    logic [2:0] cap_regsrc [16];
    logic [1:0] cap_imm    [16];

    arm_multicycle_controller #(.FETCH_INC(4)) dut (
        .clk(clk), .reset_n(reset_n), .Instr(Instr), .ALUFlags(ALUFlags),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Shifter_control(Shifter_control), .shamt(shamt), .Flags(Flags), .state(state)
    );

    always #5 clk = ~clk;

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level model: the list of states visited and the write
    // enables expected in each, derived from the instruction class.
    function automatic void model(input logic [31:0] ins, input logic [3:0] f, output bit is_cmp);
        bit ce, pc_dst;
        logic [1:0] op;
        logic [5:0] fn;
        logic [3:0] cmd;
        ce = cond_ok(ins[31:28], f);
        op = ins[27:26];
        fn = ins[25:20];
        cmd = fn[4:1];
        pc_dst = (ins[15:12] == 4'hF);
        is_cmp = 1'b0;
        exp_q.delete();
        exp_q.push_back('{0, 1, 1, 0, 0});
        exp_q.push_back('{1, 0, 0, 0, 0});
        if (op == 2'b01) begin
            exp_q.push_back('{2, 0, 0, 0, 0});
            if (fn[0]) begin
                exp_q.push_back('{3, 0, 0, 0, 0});
                exp_q.push_back('{4, 0, ce && pc_dst, ce, 0});
            end else begin
                exp_q.push_back('{5, 0, 0, 0, ce});
            end
        end else if (op == 2'b10) begin
            exp_q.push_back('{9, 0, ce, ce && fn[4], 0});
        end else if (op == 2'b00) begin
            if (fn == 6'b010010 && pc_dst) begin
                exp_q.push_back('{9, 0, ce, 0, 0});
            end else begin
                exp_q.push_back('{fn[5] ? 7 : 6, 0, 0, 0, 0});
                if (cmd inside {4'b0000, 4'b1100, 4'b0100, 4'b0010, 4'b1101})
                    exp_q.push_back('{8, 0, ce && pc_dst, ce, 0});
                else if (cmd == 4'b1010)
                    is_cmp = ce;
            end
        end
    endfunction

    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af, input string tag);
        bit upd;
        step_t s;
        logic [6:0] exp_sh;
        model(ins, mflags, upd);
        Instr = ins;
        ALUFlags = af;
        for (int i = 0; i < exp_q.size(); i++) begin
            s = exp_q[i];
            @(negedge clk);
            checks++;
            if ({state, IRWrite, PCWrite, RegWrite, MemWrite} !== {4'(s.st), s.irw, s.pcw, s.rw, s.mw}) begin
                errors++;
                $display("FAIL %s step%0d state/we: got st=%0d irw%b pcw%b rw%b mw%b want st=%0d irw%b pcw%b rw%b mw%b (instr %h)",
                         tag, i, state, IRWrite, PCWrite, RegWrite, MemWrite, s.st, s.irw, s.pcw, s.rw, s.mw, ins);
            end
            checks++;
            if (Flags !== mflags) begin
                errors++;
                $display("FAIL %s step%0d flags: got %b want %b", tag, i, Flags, mflags);
            end
            if (s.st == 7)      exp_sh = {2'b11, ins[11:8], 1'b0};
            else if (s.st == 6) exp_sh = {ins[6:5], ins[11:7]};
            else                exp_sh = '0;
            checks++;
            if ({Shifter_control, shamt} !== exp_sh) begin
                errors++;
                $display("FAIL %s step%0d shifter: got %b/%b want %b/%b", tag, i,
                         Shifter_control, shamt, exp_sh[6:5], exp_sh[4:0]);
            end
            cap_aluc[state]   = ALUControl;
            cap_adrsrc[state] = AdrSrc;
            cap_res[state]    = ResultSrc;
            cap_regsrc[state] = RegSrc;
            cap_imm[state]    = ImmSrc;
            @(posedge clk);
            #1;
        end
        if (upd) mflags = af;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        Instr = 32'h0;
        ALUFlags = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({state, Flags} !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got st=%0d flags=%b want st=0 flags=0000", state, Flags);
        end
        checks++;
        if ({IRWrite, PCWrite, RegWrite, MemWrite} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_we: got %b want 0000", {IRWrite, PCWrite, RegWrite, MemWrite});
        end
        reset_n = 1'b1;
        mflags = 4'b0000;
    endtask

    task automatic test_add();
        run_instr(32'hE2821005, 4'h0, "add_imm");
        checks++;
        if (cap_aluc[7] !== 4'b0100) begin
            errors++;
            $display("FAIL add_aluctl: got %b want 0100", cap_aluc[7]);
        end
    endtask

    task automatic test_cmp_flags();
        run_instr(32'hE1510001, 4'b0100, "cmp");
        checks++;
        if (cap_aluc[6] !== 4'b0010) begin
            errors++;
            $display("FAIL cmp_aluctl: got %b want 0010", cap_aluc[6]);
        end
        checks++;
        if (Flags !== 4'b0100) begin
            errors++;
            $display("FAIL cmp_flags: got %b want 0100", Flags);
        end
        run_instr(32'h12821005, 4'h0, "addne");
    endtask

    task automatic test_ldr();
        run_instr(32'hE5110008, 4'h0, "ldr");
        checks++;
        if (cap_aluc[2] !== 4'b0010) begin
            errors++;
            $display("FAIL ldr_memadr_alu: got %b want 0010", cap_aluc[2]);
        end
        checks++;
        if ({cap_adrsrc[3], cap_adrsrc[4], cap_res[4], cap_imm[2]} !== 6'b110101) begin
            errors++;
            $display("FAIL ldr_paths: got adr3=%b adr4=%b res4=%b imm2=%b want 1 1 01 01",
                     cap_adrsrc[3], cap_adrsrc[4], cap_res[4], cap_imm[2]);
        end
    endtask

    task automatic test_branch();
        run_instr(32'hEB000002, 4'h0, "bl");
        checks++;
        if ({cap_regsrc[9], cap_imm[9], cap_res[9]} !== 7'b1011010) begin
            errors++;
            $display("FAIL bl_ctl: got regsrc=%b imm=%b res=%b want 101 10 10",
                     cap_regsrc[9], cap_imm[9], cap_res[9]);
        end
        run_instr(32'hE1A0F003, 4'h0, "mov_pc");
        checks++;
        if (cap_aluc[6] !== 4'b1101) begin
            errors++;
            $display("FAIL mov_aluctl: got %b want 1101", cap_aluc[6]);
        end
        run_instr(32'hE12FFF13, 4'h0, "bx");
        checks++;
        if (cap_aluc[9] !== 4'b1101) begin
            errors++;
            $display("FAIL bx_aluctl: got %b want 1101", cap_aluc[9]);
        end
    endtask

    task automatic test_nop_cases();
        run_instr(32'hEE000000, 4'h0, "undef_op11");
        run_instr(32'hF5010004, 4'h0, "str_never");
        run_instr(32'hE0E12003, 4'h0, "unsupported_cmd");
    endtask

    task automatic test_reset_midinstr();
        run_instr(32'hE1510001, 4'b1010, "cmp_pre");
        Instr = 32'hE5810004;
        ALUFlags = 4'h0;
        @(negedge clk);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if ({state, MemWrite} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL str_before_reset: got st=%0d mw=%b want st=5 mw=1", state, MemWrite);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({IRWrite, PCWrite, RegWrite, MemWrite} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_we: got %b want 0000", {IRWrite, PCWrite, RegWrite, MemWrite});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({state, Flags} !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_state: got st=%0d flags=%b want st=0 flags=0000", state, Flags);
        end
        reset_n = 1'b1;
        mflags = 4'b0000;
        run_instr(32'hE2821005, 4'h0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int i = 0; i < 200; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                ins[27:26] = 2'b00;
                ins[24:21] = 4'b1010;
            end
            if ($urandom_range(0, 5) == 0) ins[15:12] = 4'hF;
            run_instr(ins, 4'($urandom_range(0, 15)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp_flags();
        test_ldr();
        test_branch();
        test_nop_cases();
        test_reset_midinstr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
